// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are converted to magnitudes when the operation is accepted.
// The unsigned magnitude product is accumulated one multiplier bit per clock,
// and the sign is applied when the product register is written.
//
// Ports:
//   clk          rising-edge clock
//   areset       asynchronous, active-low reset
//   start        operation request, accepted in IDLE or DONE
//   signed_mode  1 = two's-complement operands (sampled with start)
//   multiplicand operand A (sampled with start)
//   multiplier   operand B (sampled with start)
//   busy         high while the multiply is running
//   done         one-cycle pulse; product is valid from this cycle on
//   product      result register, held until the next result is written
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state, next_state;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        bit_cnt;
    logic                 neg;

    logic                 accept;
    logic                 last_step;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod_next;

    // |-2^(W-1)| wraps back to 2^(W-1), which is correct when read as unsigned.
    always_comb begin
        a_abs = multiplicand;
        b_abs = multiplier;
        if (signed_mode && multiplicand[WIDTH-1]) a_abs = -multiplicand;
        if (signed_mode && multiplier[WIDTH-1])   b_abs = -multiplier;
    end

    // Add into the upper half, then shift the whole accumulator right by one;
    // the carry becomes the new MSB and sum[0] drops into the lower half.
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (b_mag[0] ? a_mag : '0)};
        acc_next  = {sum, acc[WIDTH-1:1]};
        prod_next = neg ? -acc_next : acc_next;
    end

    always_comb begin
        accept     = start && (state != S_RUN);
        last_step  = (state == S_RUN) && (bit_cnt == CW'(WIDTH - 1));
        next_state = state;
        busy       = (state == S_RUN);
        done       = (state == S_DONE);
        case (state)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (last_step) next_state = S_DONE;
            S_DONE:  next_state = start ? S_RUN : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state   <= S_IDLE;
            a_mag   <= '0;
            b_mag   <= '0;
            acc     <= '0;
            bit_cnt <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_mag   <= a_abs;
                b_mag   <= b_abs;
                neg     <= signed_mode && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                acc     <= '0;
                bit_cnt <= '0;
            end else if (state == S_RUN) begin
                acc     <= acc_next;
                b_mag   <= b_mag >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (last_step) product <= prod_next;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: randomized and directed checking of seq_multiplier at
// WIDTH=8 and WIDTH=16 against a cycle-level behavioural model that computes
// products with plain integer arithmetic.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        st [2];
    logic        sm [2];
    logic [31:0] opa [2];
    logic [31:0] opb [2];

    logic        busy0, done0, busy1, done1;
    logic [15:0] prod0;
    logic [31:0] prod1;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .areset(areset), .start(st[0]), .signed_mode(sm[0]),
        .multiplicand(opa[0][7:0]), .multiplier(opb[0][7:0]),
        .busy(busy0), .done(done0), .product(prod0)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .areset(areset), .start(st[1]), .signed_mode(sm[1]),
        .multiplicand(opa[1][15:0]), .multiplier(opb[1][15:0]),
        .busy(busy1), .done(done1), .product(prod1)
    );

    function automatic logic get_busy(int k);
        return (k == 1) ? busy1 : busy0;
    endfunction

    function automatic logic get_done(int k);
        return (k == 1) ? done1 : done0;
    endfunction

    function automatic logic [63:0] get_prod(int k);
        return (k == 1) ? {32'd0, prod1} : {48'd0, prod0};
    endfunction

    function automatic int wid(int k);
        return (k == 1) ? 16 : 8;
    endfunction

    // Reference product: integer multiply of the interpreted operands, truncated to 2w bits.
    function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, bit s, int w);
        longint    sa, sb;
        logic [63:0] p, m;
        m  = (64'd1 << w) - 64'd1;
        sa = longint'({32'd0, a} & m);
        sb = longint'({32'd0, b} & m);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p = 64'(sa * sb);
        return p & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted op produces its result WIDTH edges later,
    // requests arriving while an op is in flight are dropped.
    int          left  [2] = '{0, 0};
    logic [63:0] pend  [2] = '{64'd0, 64'd0};
    logic [63:0] eprod [2] = '{64'd0, 64'd0};
    bit          ebusy [2] = '{1'b0, 1'b0};
    bit          edone [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge areset) begin
        for (int k = 0; k < 2; k++) begin
            if (!areset) begin
                left[k] = 0; ebusy[k] = 1'b0; edone[k] = 1'b0; eprod[k] = 64'd0;
            end else if (left[k] > 0) begin
                left[k]--;
                if (left[k] == 0) begin
                    eprod[k] = pend[k]; edone[k] = 1'b1; ebusy[k] = 1'b0;
                end
            end else begin
                edone[k] = 1'b0;
                if (st[k]) begin
                    pend[k]  = ref_mul(opa[k], opb[k], sm[k], wid(k));
                    left[k]  = wid(k);
                    ebusy[k] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("busy%0d", wid(k)), {63'd0, get_busy(k)}, {63'd0, ebusy[k]});
                check($sformatf("done%0d", wid(k)), {63'd0, get_done(k)}, {63'd0, edone[k]});
                check($sformatf("product%0d", wid(k)), get_prod(k), eprod[k]);
            end
        end
    end

    // Launch one op on instance k and wait (bounded) for its done pulse.
    // Operands are scrambled after acceptance; pulse_at != 0 adds a mid-run start.
    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b, input bit s,
                         input int pulse_at, output int edges, output int busy_cnt);
        @(posedge clk); #2;
        st[k] = 1'b1; sm[k] = s; opa[k] = a; opb[k] = b;
        edges = 0; busy_cnt = 0;
        do begin
            @(posedge clk); edges++; #2;
            if (edges == 1) begin
                st[k] = 1'b0; opa[k] = $urandom; opb[k] = $urandom; sm[k] = ~s;
            end
            if (pulse_at != 0 && edges == pulse_at) st[k] = 1'b1;
            if (pulse_at != 0 && edges == pulse_at + 1) st[k] = 1'b0;
            @(negedge clk);
            if (get_busy(k)) busy_cnt++;
        end while (!get_done(k) && edges < 40);
        if (!get_done(k)) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic directed(input string name, input int k, input logic [31:0] a,
                            input logic [31:0] b, input bit s, input logic [63:0] exp);
        int e, bc;
        do_op(k, a, b, s, 0, e, bc);
        check({name, "_dut"}, get_prod(k), exp);
        check({name, "_model"}, eprod[k], exp);
        check({name, "_latency"}, 64'(e), 64'(wid(k) + 1));
    endtask

    initial begin
        int e, bc, d1, d2;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0; sm[k] = 1'b0; opa[k] = 32'd0; opb[k] = 32'd0;
        end
        #1 areset = 1'b0;
        #20;
        check("reset_busy", {63'd0, busy0}, 64'd0);
        check("reset_done", {63'd0, done0}, 64'd0);
        check("reset_product", {48'd0, prod0}, 64'd0);
        @(posedge clk); #2 areset = 1'b1;
        cmp_on = 1'b1;

        do_op(0, 32'd13, 32'd11, 1'b0, 0, e, bc);
        check("u13x11", get_prod(0), 64'd143);
        check("u13x11_latency", 64'(e), 64'd9);
        check("u13x11_busy_cycles", 64'(bc), 64'd8);

        directed("u255x255", 0, 32'hFF, 32'hFF, 1'b0, 64'hFE01);
        directed("s255x255", 0, 32'hFF, 32'hFF, 1'b1, 64'h0001);
        directed("s-128x-128", 0, 32'h80, 32'h80, 1'b1, 64'h4000);
        directed("s-3x5", 0, 32'hFD, 32'h05, 1'b1, 64'hFFF1);
        directed("s127x-128", 0, 32'h7F, 32'h80, 1'b1, 64'hC080);
        directed("u0x200", 0, 32'h00, 32'hC8, 1'b0, 64'h0000);
        directed("w16_ffffxffff", 1, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE0001);

        // Mid-run start with new operands must be ignored.
        do_op(0, 32'd13, 32'd11, 1'b0, 3, e, bc);
        check("midrun_result", get_prod(0), 64'd143);
        check("midrun_latency", 64'(e), 64'd9);
        repeat (3) @(negedge clk);
        check("midrun_no_extra_done", {63'd0, done0}, 64'd0);

        // Start held through DONE: second op accepted on the DONE edge.
        @(posedge clk); #2;
        st[0] = 1'b1; sm[0] = 1'b0; opa[0] = 32'd13; opb[0] = 32'd11;
        e = 0; d1 = -1; d2 = -1;
        while (d2 < 0 && e < 40) begin
            @(posedge clk); e++; #2;
            if (e == 1) begin opa[0] = 32'hFF; opb[0] = 32'hFF; end
            if (e == 10) st[0] = 1'b0;
            @(negedge clk);
            if (done0 && d1 < 0) begin
                d1 = e; check("b2b_first", {48'd0, prod0}, 64'd143);
            end else if (done0) begin
                d2 = e; check("b2b_second", {48'd0, prod0}, 64'hFE01);
            end
        end
        check("b2b_spacing", 64'(d2 - d1), 64'd9);

        // Reset during RUN aborts the op.
        repeat (2) @(posedge clk);
        #2 st[0] = 1'b1; sm[0] = 1'b0; opa[0] = 32'd7; opb[0] = 32'd9;
        @(posedge clk); #2 st[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 areset = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy0}, 64'd0);
        check("abort_done", {63'd0, done0}, 64'd0);
        check("abort_product", {48'd0, prod0}, 64'd0);
        @(posedge clk); #2 areset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("abort_no_done", {63'd0, done0}, 64'd0);
        end
        directed("after_abort_s-3x5", 0, 32'hFD, 32'h05, 1'b1, 64'hFFF1);

        // Random traffic on both widths, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            areset = ($urandom_range(0, 399) != 0);
            for (int k = 0; k < 2; k++) begin
                st[k]  = ($urandom_range(0, 3) == 0);
                sm[k]  = $urandom_range(0, 1) == 1;
                opa[k] = $urandom;
                opb[k] = $urandom;
                if ($urandom_range(0, 7) == 0) opa[k] = (k == 1) ? 32'h8000 : 32'h80;
                if ($urandom_range(0, 7) == 0) opb[k] = 32'hFFFF_FFFF;
            end
        end
        @(posedge clk); #2 areset = 1'b1;
        st[0] = 1'b0; st[1] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
